rs232: RTL and testbench

- Switch-to-LED link over an RS-232 style UART (8N1, LSB first).
- Whenever the synchronized 8-bit switch value differs from the last value transmitted, the block sends that value as one frame on tx.
- Every correctly framed byte received on rx is shown on leds.
- Two instances cross-connected (tx to the other's rx) mirror each board's switches onto the other board's LEDs.

---
 rtl/rs232.sv | 218 +++++++++++++++++++++
 tb/tb_rs232.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs232.sv
// Switch-to-LED UART link: transmits the synchronized switch byte whenever it
// changes and shows every correctly framed received byte on the LEDs (8N1, LSB first).
module rs232 #(
   parameter int CLK_FREQ  = 50000000,
   parameter int BAUD_RATE = 9600
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] switches,
   input  logic       rx,
   output logic       tx,
   output logic [7:0] leds
);

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
   localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP
   } state_t;

   // Two-flop synchronizers, loaded with idle levels on reset.
   logic [7:0] sw_s1_q, sw_s2_q;
   logic       rx_s1_q, rx_s2_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         sw_s1_q <= 8'h00;
         sw_s2_q <= 8'h00;
         rx_s1_q <= 1'b1;
         rx_s2_q <= 1'b1;
      end else begin
         sw_s1_q <= switches;
         sw_s2_q <= sw_s1_q;
         rx_s1_q <= rx;
         rx_s2_q <= rx_s1_q;
      end
   end

   // ------------------------------------------------------------------ TX
   state_t           tx_state_q;
   logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
   logic [2:0]       tx_bit_q, tx_bit_d;
   logic [7:0]       tx_shift_q;
   logic [7:0]       last_sent_q;
   logic             tx_q;
   logic             tx_bit_end;
   logic             tx_change;

   always_comb begin
      tx_cnt_d   = tx_cnt_q + CNT_W'(1);
      tx_bit_d   = tx_bit_q + 3'd1;
      tx_bit_end = (tx_cnt_q == BIT_LAST);
      tx_change  = (sw_s2_q != last_sent_q);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         tx_state_q  <= ST_IDLE;
         tx_cnt_q    <= '0;
         tx_bit_q    <= 3'd0;
         tx_shift_q  <= 8'h00;
         last_sent_q <= 8'h00;
         tx_q        <= 1'b1;
      end else begin
         case (tx_state_q)
            ST_IDLE: begin
               tx_q <= 1'b1;
               if (tx_change) begin
                  tx_shift_q  <= sw_s2_q;
                  last_sent_q <= sw_s2_q;
                  tx_cnt_q    <= '0;
                  tx_bit_q    <= 3'd0;
                  tx_q        <= 1'b0;
                  tx_state_q  <= ST_START;
               end
            end
            ST_START: begin
               if (tx_bit_end) begin
                  tx_cnt_q   <= '0;
                  tx_q       <= tx_shift_q[0];
                  tx_state_q <= ST_DATA;
               end else begin
                  tx_cnt_q <= tx_cnt_d;
               end
            end
            ST_DATA: begin
               if (tx_bit_end) begin
                  tx_cnt_q <= '0;
                  if (tx_bit_q == 3'd7) begin
                     tx_q       <= 1'b1;
                     tx_state_q <= ST_STOP;
                  end else begin
                     tx_bit_q <= tx_bit_d;
                     tx_q     <= tx_shift_q[tx_bit_d];
                  end
               end else begin
                  tx_cnt_q <= tx_cnt_d;
               end
            end
            ST_STOP: begin
               if (tx_bit_end) begin
                  tx_cnt_q <= '0;
                  // A pending change starts the next frame with no idle gap.
                  if (tx_change) begin
                     tx_shift_q  <= sw_s2_q;
                     last_sent_q <= sw_s2_q;
                     tx_bit_q    <= 3'd0;
                     tx_q        <= 1'b0;
                     tx_state_q  <= ST_START;
                  end else begin
                     tx_q       <= 1'b1;
                     tx_state_q <= ST_IDLE;
                  end
               end else begin
                  tx_cnt_q <= tx_cnt_d;
               end
            end
            default: begin
               tx_q       <= 1'b1;
               tx_state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign tx = tx_q;

   // ------------------------------------------------------------------ RX
   state_t           rx_state_q;
   logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
   logic [2:0]       rx_bit_q, rx_bit_d;
   logic [7:0]       rx_shift_q;
   logic             rx_armed_q;
   logic [7:0]       leds_q;
   logic             rx_bit_end;
   logic             rx_half_end;

   always_comb begin
      rx_cnt_d    = rx_cnt_q + CNT_W'(1);
      rx_bit_d    = rx_bit_q + 3'd1;
      rx_bit_end  = (rx_cnt_q == BIT_LAST);
      rx_half_end = (rx_cnt_q == HALF_LAST);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rx_state_q <= ST_IDLE;
         rx_cnt_q   <= '0;
         rx_bit_q   <= 3'd0;
         rx_shift_q <= 8'h00;
         rx_armed_q <= 1'b1;
         leds_q     <= 8'h00;
      end else begin
         case (rx_state_q)
            ST_IDLE: begin
               rx_cnt_q <= '0;
               // After a framing error the line must return high before re-arming.
               if (!rx_armed_q) begin
                  if (rx_s2_q) rx_armed_q <= 1'b1;
               end else if (!rx_s2_q) begin
                  rx_state_q <= ST_START;
               end
            end
            ST_START: begin
               if (rx_half_end) begin
                  rx_cnt_q <= '0;
                  if (rx_s2_q) begin
                     rx_state_q <= ST_IDLE;
                  end else begin
                     rx_bit_q   <= 3'd0;
                     rx_state_q <= ST_DATA;
                  end
               end else begin
                  rx_cnt_q <= rx_cnt_d;
               end
            end
            ST_DATA: begin
               if (rx_bit_end) begin
                  rx_cnt_q   <= '0;
                  rx_shift_q <= {rx_s2_q, rx_shift_q[7:1]};
                  if (rx_bit_q == 3'd7) begin
                     rx_state_q <= ST_STOP;
                  end else begin
                     rx_bit_q <= rx_bit_d;
                  end
               end else begin
                  rx_cnt_q <= rx_cnt_d;
               end
            end
            ST_STOP: begin
               if (rx_bit_end) begin
                  rx_cnt_q   <= '0;
                  rx_state_q <= ST_IDLE;
                  if (rx_s2_q) begin
                     leds_q <= rx_shift_q;
                  end else begin
                     rx_armed_q <= 1'b0;
                  end
               end else begin
                  rx_cnt_q <= rx_cnt_d;
               end
            end
            default: begin
               rx_state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign leds = leds_q;

endmodule

// File: tb/tb_rs232.sv
// Bench for rs232: cross-connected pair A/B plus a third instance C whose rx
// is driven directly; clock 10 ns, CLKS_PER_BIT reduced to 16.
module tb_rs232;

   localparam int CPB = 16;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] sw_a = 8'h00, sw_b = 8'h00;
   logic       rx_c = 1'b1;
   logic       tx_a, tx_b, tx_c;
   logic [7:0] leds_a, leds_b, leds_c;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   rs232 #(.CLK_FREQ(1600), .BAUD_RATE(100)) u_a (
      .clk(clk), .reset(reset), .switches(sw_a), .rx(tx_b), .tx(tx_a), .leds(leds_a));
   rs232 #(.CLK_FREQ(1600), .BAUD_RATE(100)) u_b (
      .clk(clk), .reset(reset), .switches(sw_b), .rx(tx_a), .tx(tx_b), .leds(leds_b));
   rs232 #(.CLK_FREQ(1600), .BAUD_RATE(100)) u_c (
      .clk(clk), .reset(reset), .switches(8'h00), .rx(rx_c), .tx(tx_c), .leds(leds_c));

   // Waits for a start bit on tx_a or tx_b, then samples both lines mid-bit.
   // lat = number of rising edges from the call to the first low sample.
   task automatic capture_frames(output logic [9:0] fa, output logic [9:0] fb,
                                 output bit timeout, output int lat);
      int n;
      fa = '1; fb = '1; timeout = 1'b1; lat = 0; n = 0;
      while (n < 4 * CPB) begin
         @(posedge clk); #1;
         n++;
         if (tx_a === 1'b0 || tx_b === 1'b0) begin
            timeout = 1'b0;
            break;
         end
      end
      lat = n;
      if (!timeout) begin
         repeat (CPB / 2) @(posedge clk);
         #1;
         fa[0] = tx_a; fb[0] = tx_b;
         for (int k = 1; k < 10; k++) begin
            repeat (CPB) @(posedge clk);
            #1;
            fa[k] = tx_a; fb[k] = tx_b;
         end
      end
   endtask

   task automatic wait_leds(input logic [7:0] exp_a, input logic [7:0] exp_b);
      for (int i = 0; i < 2 * CPB; i++) begin
         @(posedge clk); #1;
         if (leds_a === exp_a && leds_b === exp_b) break;
      end
   endtask

   task automatic send_rx(input logic [7:0] data, input logic stop_bit);
      logic [9:0] bits;
      bits = {stop_bit, data, 1'b0};
      for (int k = 0; k < 10; k++) begin
         @(negedge clk) rx_c = bits[k];
         repeat (CPB - 1) @(negedge clk);
      end
      @(negedge clk) rx_c = 1'b1;
      repeat (2 * CPB) @(negedge clk);
   endtask

   task automatic test_reset;
      int lows;
      reset = 1'b1; sw_a = 8'h00; sw_b = 8'h00; rx_c = 1'b1;
      repeat (20) @(posedge clk);
      @(negedge clk) reset = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (tx_a !== 1'b1 || tx_b !== 1'b1) begin
         errors++;
         $display("FAIL reset_tx: got a=%b b=%b, expected 1 1", tx_a, tx_b);
      end
      checks++;
      if (leds_a !== 8'h00 || leds_b !== 8'h00 || leds_c !== 8'h00) begin
         errors++;
         $display("FAIL reset_leds: got a=%h b=%h c=%h, expected 00", leds_a, leds_b, leds_c);
      end
      lows = 0;
      repeat (20 * CPB) begin
         @(posedge clk); #1;
         if (tx_a !== 1'b1 || tx_b !== 1'b1 || tx_c !== 1'b1) lows++;
      end
      checks++;
      if (lows != 0) begin
         errors++;
         $display("FAIL reset_no_frame: got %0d low cycles, expected 0", lows);
      end
      $display("reset: released, lines idle");
   endtask

   task automatic test_a_to_b;
      logic [9:0] fa, fb; bit to; int lat;
      @(negedge clk) sw_a = 8'h01;
      capture_frames(fa, fb, to, lat);
      checks++;
      if (to || fa !== 10'b1_00000001_0 || fb !== 10'h3FF) begin
         errors++;
         $display("FAIL a_frame_01: got a=%b b=%b to=%0d, expected a=1000000010 b=1111111111", fa, fb, to);
      end
      checks++;
      if (lat < 2 || lat > 4) begin
         errors++;
         $display("FAIL a_latency: got %0d cycles, expected 3 +/-1", lat);
      end
      wait_leds(8'h00, 8'h01);
      checks++;
      if (leds_b !== 8'h01 || leds_a !== 8'h00) begin
         errors++;
         $display("FAIL a_to_b_leds: got a=%h b=%h, expected a=00 b=01", leds_a, leds_b);
      end
      $display("A->B frame %b latency %0d leds_b=%h", fa, lat, leds_b);
   endtask

   task automatic test_b_to_a;
      logic [9:0] fa, fb; bit to; int lat;
      @(negedge clk) sw_b = 8'hF0;
      capture_frames(fa, fb, to, lat);
      checks++;
      if (to || fb !== 10'b1_11110000_0 || fa !== 10'h3FF) begin
         errors++;
         $display("FAIL b_frame_f0: got a=%b b=%b to=%0d, expected a=1111111111 b=1111100000", fa, fb, to);
      end
      wait_leds(8'hF0, 8'h01);
      checks++;
      if (leds_a !== 8'hF0 || leds_b !== 8'h01) begin
         errors++;
         $display("FAIL b_to_a_leds: got a=%h b=%h, expected a=f0 b=01", leds_a, leds_b);
      end
      $display("B->A frame %b leds_a=%h", fb, leds_a);
   endtask

   task automatic test_full_duplex;
      logic [9:0] fa, fb; bit to; int lat;
      @(negedge clk) begin sw_a = 8'hAA; sw_b = 8'h55; end
      capture_frames(fa, fb, to, lat);
      checks++;
      if (to || fa !== 10'b1_10101010_0 || fb !== 10'b1_01010101_0) begin
         errors++;
         $display("FAIL duplex_frames: got a=%b b=%b to=%0d, expected a=1101010100 b=1010101010", fa, fb, to);
      end
      wait_leds(8'h55, 8'hAA);
      checks++;
      if (leds_a !== 8'h55 || leds_b !== 8'hAA) begin
         errors++;
         $display("FAIL duplex_leds: got a=%h b=%h, expected a=55 b=aa", leds_a, leds_b);
      end
      $display("duplex frames a=%b b=%b leds a=%h b=%h", fa, fb, leds_a, leds_b);
   endtask

   task automatic test_back_to_back;
      logic [9:0] fa1, fb1, fa2, fb2; bit to1, to2; int lat; int lows;
      @(negedge clk) sw_a = 8'h11;
      fork
         capture_frames(fa1, fb1, to1, lat);
         begin
            repeat (3 * CPB) @(negedge clk);
            sw_a = 8'h22;
            repeat (2 * CPB) @(negedge clk);
            sw_a = 8'h33;
         end
      join
      capture_frames(fa2, fb2, to2, lat);
      checks++;
      if (to1 || fa1 !== 10'b1_00010001_0) begin
         errors++;
         $display("FAIL b2b_first: got %b to=%0d, expected 1000100010", fa1, to1);
      end
      checks++;
      if (to2 || fa2 !== 10'b1_00110011_0) begin
         errors++;
         $display("FAIL b2b_second: got %b to=%0d, expected 1001100110", fa2, to2);
      end
      lows = 0;
      repeat (12 * CPB) begin
         @(posedge clk); #1;
         if (tx_a !== 1'b1) lows++;
      end
      checks++;
      if (lows != 0) begin
         errors++;
         $display("FAIL b2b_no_third: got %0d low cycles, expected 0", lows);
      end
      checks++;
      if (leds_b !== 8'h33) begin
         errors++;
         $display("FAIL b2b_leds: got %h, expected 33", leds_b);
      end
      $display("back-to-back frames %b then %b leds_b=%h", fa1, fa2, leds_b);
   endtask

   task automatic test_rx_direct;
      @(negedge clk) rx_c = 1'b0;
      repeat (CPB / 4) @(negedge clk);
      rx_c = 1'b1;
      repeat (2 * CPB) @(negedge clk);
      checks++;
      if (leds_c !== 8'h00) begin
         errors++;
         $display("FAIL rx_glitch: got %h, expected 00", leds_c);
      end
      $display("rx glitch leds_c=%h", leds_c);
      send_rx(8'hC3, 1'b0);
      checks++;
      if (leds_c !== 8'h00) begin
         errors++;
         $display("FAIL rx_framing: got %h, expected 00", leds_c);
      end
      $display("rx framing-error frame leds_c=%h", leds_c);
      send_rx(8'h5A, 1'b1);
      checks++;
      if (leds_c !== 8'h5A) begin
         errors++;
         $display("FAIL rx_5a: got %h, expected 5a", leds_c);
      end
      $display("rx frame 5a leds_c=%h", leds_c);
      send_rx(8'h81, 1'b1);
      checks++;
      if (leds_c !== 8'h81) begin
         errors++;
         $display("FAIL rx_81: got %h, expected 81", leds_c);
      end
      $display("rx frame 81 leds_c=%h", leds_c);
   endtask

   task automatic test_reset_mid_frame;
      int n; int lows; bit seen;
      @(negedge clk) sw_a = 8'h0F;
      seen = 1'b0;
      for (n = 0; n < 4 * CPB; n++) begin
         @(posedge clk); #1;
         if (tx_a === 1'b0) begin seen = 1'b1; break; end
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL midreset_start: got no start bit, expected tx_a low");
      end
      @(negedge clk) begin reset = 1'b1; sw_a = 8'h00; sw_b = 8'h00; end
      @(posedge clk); #1;
      checks++;
      if (tx_a !== 1'b1 || leds_a !== 8'h00 || leds_b !== 8'h00 || leds_c !== 8'h00) begin
         errors++;
         $display("FAIL midreset_state: got tx_a=%b leds a=%h b=%h c=%h, expected 1 00 00 00",
                  tx_a, leds_a, leds_b, leds_c);
      end
      @(negedge clk) reset = 1'b0;
      lows = 0;
      repeat (12 * CPB) begin
         @(posedge clk); #1;
         if (tx_a !== 1'b1 || tx_b !== 1'b1) lows++;
      end
      checks++;
      if (lows != 0) begin
         errors++;
         $display("FAIL midreset_no_frame: got %0d low cycles, expected 0", lows);
      end
      $display("mid-frame reset tx_a=%b leds_a=%h", tx_a, leds_a);
   endtask

   initial begin
      test_reset();
      test_a_to_b();
      test_b_to_a();
      test_full_duplex();
      test_back_to_back();
      test_rx_direct();
      test_reset_mid_frame();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
